// File: rtl/aes128_pipe_top.sv
// aes128_pipe_top: fully pipelined AES-128 encryptor, 21 register stages, one block per clock.
// Optional macro AES_OUT_VALID_EN adds a registered out_valid flag for the pipeline fill.
`default_nettype none

module aes128_pipe_top (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state,
  input  logic [127:0] key,
`ifdef AES_OUT_VALID_EN
  output logic         out_valid,
`endif
  output logic [127:0] out
);

  // FIPS-197 S-box, byte b lives at [2047-8*b -: 8]
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = sbox(x[8*i +: 8]);
    return y;
  endfunction

  // Byte r+4c of the result takes row r from column (c+r) mod 4
  function automatic logic [127:0] shift_rows(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127 - 8*(r + 4*c) -: 8] = x[127 - 8*(r + 4*((c + r) % 4)) -: 8];
    return y;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0]   a0, a1, a2, a3;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127 - 32*c -: 8];
      a1 = x[119 - 32*c -: 8];
      a2 = x[111 - 32*c -: 8];
      a3 = x[103 - 32*c -: 8];
      y[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return y;
  endfunction

  function automatic logic [7:0] rcon(input int r);
    case (r)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      default: return 8'h36;
    endcase
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, rot;
    w0  = k[127:96];
    w1  = k[95:64];
    w2  = k[63:32];
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
    w0  = w0 ^ t;
    w1  = w1 ^ w0;
    w2  = w2 ^ w1;
    w3  = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Stage a of round r: SubBytes result plus that round's key.
  // Stage b of round r: round output plus the key it consumed, for the next round.
  logic [127:0] data_a [1:10];
  logic [127:0] key_a  [1:10];
  logic [127:0] data_b [0:10];
  logic [127:0] key_b  [0:9];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_b[0] <= '0;
      key_b[0]  <= '0;
      for (int r = 1; r <= 10; r++) begin
        data_a[r] <= '0;
        key_a[r]  <= '0;
        data_b[r] <= '0;
        if (r < 10) key_b[r] <= '0;
      end
    end else begin
      data_b[0] <= state ^ key;
      key_b[0]  <= key;
      for (int r = 1; r <= 10; r++) begin
        data_a[r] <= sub_bytes(data_b[r-1]);
        key_a[r]  <= next_key(key_b[r-1], rcon(r));
        if (r < 10) begin
          data_b[r] <= mix_columns(shift_rows(data_a[r])) ^ key_a[r];
          key_b[r]  <= key_a[r];
        end else begin
          data_b[r] <= shift_rows(data_a[r]) ^ key_a[r];
        end
      end
    end
  end

  assign out = data_b[10];

`ifdef AES_OUT_VALID_EN
  logic [4:0] valid_cnt;

  // valid_cnt counts edges since release; the first real block lands on edge 21
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_cnt <= 5'd0;
      out_valid <= 1'b0;
    end else begin
      if (valid_cnt != 5'd21) valid_cnt <= valid_cnt + 5'd1;
      out_valid <= (valid_cnt >= 5'd20);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes128_pipe_top.sv
// tb_aes128_pipe_top: directed FIPS/known-answer vectors, latency, streaming and async reset checks.
`default_nettype none

module tb_aes128_pipe_top;

  localparam int NV = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] state;
  logic [127:0] key;
  logic [127:0] out;
`ifdef AES_OUT_VALID_EN
  logic         out_valid;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic [127:0] vs [NV];
  logic [127:0] vk [NV];
  logic [127:0] ve [NV];

  aes128_pipe_top dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .key       (key),
`ifdef AES_OUT_VALID_EN
    .out_valid (out_valid),
`endif
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ne(input string tag, input logic [127:0] obs, input logic [127:0] bad);
    n_checks++;
    assert (obs !== bad) else begin
      n_fails++;
      $error("FAIL %s: observed %h must differ from %h", tag, obs, bad);
    end
  endtask

  initial begin
    vs[0] = 128'h3243f6a8885a308d313198a2e0370734; vk[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ve[0] = 128'h3925841d02dc09fbdc118597196a0b32;
    vs[1] = 128'h00112233445566778899aabbccddeeff; vk[1] = 128'h000102030405060708090a0b0c0d0e0f;
    ve[1] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    vs[2] = 128'h0; vk[2] = 128'h0; ve[2] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    vs[3] = 128'h0; vk[3] = 128'h1; ve[3] = 128'h0545aad56da2a97c3663d1432a3d1c84;
    vs[4] = 128'h1; vk[4] = 128'h0; ve[4] = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    // same plaintext, key toggling every cycle
    vs[5] = 128'h0; vk[5] = 128'h0; ve[5] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    vs[6] = 128'h0; vk[6] = 128'h1; ve[6] = 128'h0545aad56da2a97c3663d1432a3d1c84;
    vs[7] = 128'h0; vk[7] = 128'h0; ve[7] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    vs[8] = 128'h0; vk[8] = 128'h1; ve[8] = 128'h0545aad56da2a97c3663d1432a3d1c84;

    rst   = 1'b0;
    state = vs[0];
    key   = vk[0];
    repeat (3) begin
      @(negedge clk);
      check_eq("reset_hold", out, 128'h0);
`ifdef AES_OUT_VALID_EN
      check_eq("reset_valid", {127'h0, out_valid}, 128'h0);
`endif
    end

    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c <= NV + 21; c++) begin
      if (c < NV) begin
        state = vs[c];
        key   = vk[c];
      end else begin
        state = {$urandom, $urandom, $urandom, $urandom};
        key   = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      if (c == 19) check_ne("latency_early", out, ve[0]);
      if (c >= 20 && c < 20 + NV) check_eq($sformatf("stream_vec%0d", c - 20), out, ve[c-20]);
      if (c == 20 + NV) check_ne("stream_end", out, ve[NV-1]);
`ifdef AES_OUT_VALID_EN
      check_eq($sformatf("valid_edge%0d", c + 1), {127'h0, out_valid}, {127'h0, (c >= 20)});
`endif
    end

    // asynchronous reset in the middle of a clock phase
    @(posedge clk);
    #2;
    check_ne("pre_reset_nonzero", out, 128'h0);
    rst = 1'b0;
    #1;
    check_eq("async_reset_out", out, 128'h0);
`ifdef AES_OUT_VALID_EN
    check_eq("async_reset_valid", {127'h0, out_valid}, 128'h0);
`endif
    @(negedge clk);
    check_eq("reset_held_out", out, 128'h0);

    rst = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      if (c == 0) begin
        state = vs[0];
        key   = vk[0];
      end else begin
        state = vs[1];
        key   = vk[1];
      end
      @(negedge clk);
      if (c == 19) check_ne("refill_early", out, ve[0]);
      if (c == 20) check_eq("refill_fips", out, ve[0]);
      if (c == 21) check_eq("refill_next", out, ve[1]);
`ifdef AES_OUT_VALID_EN
      check_eq($sformatf("refill_valid%0d", c + 1), {127'h0, out_valid}, {127'h0, (c >= 20)});
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/aes128_pipe_top.md
Name: aes128_pipe_top

Overview:
- Fully pipelined AES-128 encryption core per FIPS-197: 128-bit plaintext, 128-bit key, 128-bit ciphertext.
- Accepts a new plaintext/key pair every clock and delivers one ciphertext per clock at a fixed latency.
- Top-level of the crypto datapath; no handshake, no decryption.

Parameters:
- None. Key size is fixed at 128 bits and round count at 10.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  asynchronous, active-low reset. Assertion (0) clears all pipeline registers immediately.
- state  input  128  plaintext block. Bits [127:120] are FIPS byte 0; columns are filled column-major.
- key  input  128  cipher key, same byte ordering as state.
- out  output  128  ciphertext, registered, same byte ordering.

Behaviour:
- The interface has one clock. Reset is asynchronous and active-low.
- Reset: while rst=0, every pipeline register is cleared to 0, including state, round-key and output stages, so out=0. Release of rst is synchronous to clk, with no extra idle cycles.
- Input stage, edge 1:
  - state and key are sampled on a rising clk edge.
  - Stage-0 register = state XOR key (AddRoundKey 0).
  - Round-key register 0 = key.
- Rounds 1..10:
  - Each round uses exactly 2 register stages.
  - Stage a: SubBytes on the data path. In parallel, compute the next round key (RotWord, SubWord, Rcon XOR chaining).
  - Stage b: ShiftRows, MixColumns and AddRoundKey.
  - Round 10 omits MixColumns.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- Latency:
  - A pair sampled on edge N appears on out immediately after edge N+20.
  - out holds that value until edge N+21.
  - Total is 21 register stages.
- Throughput: one block per clock. Consecutive different pairs produce consecutive ciphertexts, with no interference between them. Each stage carries its own round key alongside its data.
- Idle/fill: after reset release, out shows the pipeline contents from the all-zero reset state until real data propagates. The value seen during fill is not required to be meaningful.
- Reset mid-operation: all in-flight blocks are discarded and out goes to 0 asynchronously. After release, the pipeline refills from edge 1.
- S-box:
  - Combinational, shared function used for both data bytes and key bytes.
  - Use a composite-field GF(2^8) inversion plus affine transform, or a 256-entry constant function.
  - Must match the FIPS-197 S-box exactly.
- No X propagation: out must be fully defined after reset.

Optional Feature:
- Macro AES_OUT_VALID_EN adds output out_valid (1 bit, registered).
- When defined:
  - A 5-bit counter starts at 0 on reset and increments once per clk edge after reset release, saturating at 21.
  - out_valid=1 when the counter equals 21, i.e. out carries a block sampled after reset release. Otherwise out_valid=0.
  - Reset clears the counter and out_valid asynchronously.
- When undefined: no out_valid port and no counter logic. Datapath behaviour is identical in both builds.

Test Plan:
- Reset: hold rst=0 with any inputs -> out=0 on every cycle. Assert rst=0 asynchronously mid-stream -> out goes to 0 without waiting for a clk edge.
- FIPS vector 1: state=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> out=3925841d02dc09fbdc118597196a0b32, exactly 20 edges after the sampling edge.
- Back-to-back stream, sampled on consecutive edges:
  - (00112233445566778899aabbccddeeff, 000102030405060708090a0b0c0d0e0f) -> out 69c4e0d86a7b0430d8cdb78070b4c55a
  - (0, 0) -> out 66e94bd4ef8a2c3b884cfa59ca342b2e
  - (state=0, key=1) -> out 0545aad56da2a97c3663d1432a3d1c84
  - (state=1, key=0) -> out 58e2fccefa7e3061367f1d57a4e7455a
  - Results must appear on consecutive cycles after vector 1's result, each held for exactly one cycle.
- Latency check: apply one pair and hold it for 1 cycle, then change inputs -> result appears after edge N+20, not N+19 or N+21.
- Key-only change: same plaintext with key toggled every cycle -> each output matches its own key. Confirms round keys travel with the data.
- With AES_OUT_VALID_EN: out_valid=0 for the first 20 edges after reset release, then 1 from edge 21. Reset pulse -> out_valid=0 immediately.
